// File: rtl/n101_boot_copier.sv
// n101_boot_copier: copies WORDS words out of a mask ROM into a destination write bus.
// ROM word i is written to byte address DST_BASE + 4*i. Only one write is
// outstanding at a time. If a write response carries an error, the copy stops
// and the sticky err flag is set.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle copy request; honoured only when idle
//   busy, done, err   copy in progress / one-cycle end pulse / sticky abort flag
//   rom_addr          ROM word index (equal to the internal word counter)
//   rom_dout          ROM data, combinational from rom_addr
//   cmd_*             destination write command (valid/ready handshake)
//   rsp_*             destination write response (valid/ready handshake)
module n101_boot_copier #(
   parameter int unsigned AW       = 12,
   parameter int unsigned DW       = 32,
   parameter int unsigned WORDS    = 1024,
   parameter logic [31:0] DST_BASE = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [AW-3:0]   rom_addr,
   input  logic [DW-1:0]   rom_dout,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [31:0]     cmd_addr,
   output logic [DW-1:0]   cmd_wdata,
   output logic [DW/8-1:0] cmd_wmask,
   input  logic            rsp_valid,
   input  logic            rsp_err,
   output logic            rsp_ready
);

   localparam int unsigned IW = AW - 2;
   localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

   typedef enum logic [1:0] {StIdle, StCmd, StRsp, StFin} state_e;

   state_e        state_q;
   logic [IW-1:0] idx_q;
   logic          err_q;
   logic          busy_q;
   logic          done_q;
   logic          cmd_valid_q;
   logic          rsp_ready_q;

   // Single state register; handshake outputs are registered alongside the
   // state so they are glitch-free and drop asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  err_q       <= 1'b0;
                  idx_q       <= '0;
                  busy_q      <= 1'b1;
                  cmd_valid_q <= 1'b1;
                  state_q     <= StCmd;
               end
            end
            StCmd: begin
               if (cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  rsp_ready_q <= 1'b1;
                  state_q     <= StRsp;
               end
            end
            StRsp: begin
               if (rsp_valid) begin
                  rsp_ready_q <= 1'b0;
                  if (rsp_err || (idx_q == LastIdx)) begin
                     // Abort or last word: leave through FIN, never wrap idx.
                     err_q   <= err_q | rsp_err;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     idx_q       <= idx_q + 1'b1;
                     cmd_valid_q <= 1'b1;
                     state_q     <= StCmd;
                  end
               end
            end
            StFin: begin
               state_q <= StIdle;
            end
            default: begin
               state_q     <= StIdle;
               busy_q      <= 1'b0;
               cmd_valid_q <= 1'b0;
               rsp_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cmd_valid = cmd_valid_q;
   assign rsp_ready = rsp_ready_q;
   assign rom_addr  = idx_q;
   assign cmd_wdata = rom_dout;
   assign cmd_wmask = '1;
   // Carry out of bit 31 is dropped, so the address wraps modulo 2^32.
   assign cmd_addr  = DST_BASE + {{(32 - AW){1'b0}}, idx_q, 2'b00};

endmodule
